// File: rtl/buzzer_tone_player.sv
// Piezo tone sequencer: plays up to four ROM notes per game-event pattern.
// Square wave half-period is code*HP_BASE cycles and each note lasts len*UNIT_CYCLES cycles.
module buzzer_tone_player #(
    parameter int HP_BASE     = 25000,
    parameter int UNIT_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] pattern_sel,
    input  logic       abort,
    input  logic       mute,
    output logic       buzzer_out,
    output logic       busy,
    output logic       done,
    output logic [9:0] LEDR,
    output logic [1:0] debug_step
);

    localparam int TW = $clog2(7 * HP_BASE);
    localparam int DW = $clog2(7 * UNIT_CYCLES);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t        state_q;
    logic [1:0]    sel_q;
    logic [1:0]    step_q;
    logic [TW-1:0] tone_cnt_q;
    logic [DW-1:0] dur_cnt_q;
    logic          buzz_q;
    logic          done_q;

    // Each entry is {code, len}; len == 0 terminates the pattern.
    function automatic logic [5:0] rom(input logic [1:0] sel,
                                       input logic [1:0] idx);
        logic [5:0] e;
        case ({sel, idx})
            4'b00_00: e = {3'd2, 3'd2};
            4'b00_01: e = {3'd1, 3'd2};
            4'b01_00: e = {3'd6, 3'd4};
            4'b10_00: e = {3'd3, 3'd2};
            4'b10_01: e = {3'd0, 3'd1};
            4'b10_10: e = {3'd3, 3'd2};
            4'b10_11: e = {3'd1, 3'd4};
            4'b11_00: e = {3'd4, 3'd1};
            4'b11_01: e = {3'd3, 3'd1};
            4'b11_10: e = {3'd2, 3'd1};
            4'b11_11: e = {3'd1, 3'd4};
            default:  e = 6'd0;
        endcase
        return e;
    endfunction

    logic [5:0]  entry;
    logic [5:0]  nxt_entry;
    logic [2:0]  code;
    logic [2:0]  len;
    logic [31:0] tone_top;
    logic [31:0] dur_top;
    logic        tone_end;
    logic        dur_end;
    logic        last;

    always_comb begin
        entry     = rom(sel_q, step_q);
        nxt_entry = rom(sel_q, step_q + 2'd1);
        code      = entry[5:3];
        len       = entry[2:0];
        tone_top  = 32'(code) * 32'(HP_BASE) - 32'd1;
        dur_top   = 32'(len) * 32'(UNIT_CYCLES) - 32'd1;
        tone_end  = (code != 3'd0) && (32'(tone_cnt_q) == tone_top);
        dur_end   = (32'(dur_cnt_q) == dur_top);
        last      = (step_q == 2'd3) || (nxt_entry[2:0] == 3'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sel_q      <= 2'd0;
            step_q     <= 2'd0;
            tone_cnt_q <= '0;
            dur_cnt_q  <= '0;
            buzz_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q    <= PLAY;
                        sel_q      <= pattern_sel;
                        step_q     <= 2'd0;
                        tone_cnt_q <= '0;
                        dur_cnt_q  <= '0;
                        buzz_q     <= 1'b0;
                    end
                end
                PLAY: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        step_q     <= 2'd0;
                        tone_cnt_q <= '0;
                        dur_cnt_q  <= '0;
                        buzz_q     <= 1'b0;
                    end else if (dur_end) begin
                        tone_cnt_q <= '0;
                        dur_cnt_q  <= '0;
                        buzz_q     <= 1'b0;
                        if (last) begin
                            state_q <= IDLE;
                            step_q  <= 2'd0;
                            done_q  <= 1'b1;
                        end else begin
                            step_q <= step_q + 2'd1;
                        end
                    end else begin
                        dur_cnt_q <= dur_cnt_q + 1'b1;
                        if (code == 3'd0) begin
                            tone_cnt_q <= '0;
                        end else if (tone_end) begin
                            tone_cnt_q <= '0;
                            buzz_q     <= ~buzz_q;
                        end else begin
                            tone_cnt_q <= tone_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Mute gates only the pin, so the internal phase keeps running.
    assign buzzer_out = buzz_q & ~mute;
    assign busy       = (state_q == PLAY);
    assign done       = done_q;
    assign LEDR       = {10{buzzer_out}};
    assign debug_step = step_q;

endmodule

// File: tb/tb_buzzer_tone_player.sv
// Bench for buzzer_tone_player: table-driven and random pattern runs
// against a cycle-level note/waveform model, plus reset and abort corners.
module tb_buzzer_tone_player;

    localparam int HP = 2;
    localparam int UN = 40;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] pattern_sel;
    logic       abort;
    logic       mute;
    logic       buzzer_out;
    logic       busy;
    logic       done;
    logic [9:0] LEDR;
    logic [1:0] debug_step;

    int total = 0;
    int bad   = 0;

    int codes [4][4] = '{'{2, 1, 0, 0}, '{6, 0, 0, 0},
                         '{3, 0, 3, 1}, '{4, 3, 2, 1}};
    int lens  [4][4] = '{'{2, 2, 0, 0}, '{4, 0, 0, 0},
                         '{2, 1, 2, 4}, '{1, 1, 1, 4}};

    buzzer_tone_player #(.HP_BASE(HP), .UNIT_CYCLES(UN)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .pattern_sel(pattern_sel), .abort(abort), .mute(mute),
        .buzzer_out(buzzer_out), .busy(busy), .done(done),
        .LEDR(LEDR), .debug_step(debug_step)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pat_len(input int sel);
        int s = 0;
        for (int n = 0; n < 4; n++) s += lens[sel][n] * UN;
        return s;
    endfunction

    // Cycle k (1 = first busy cycle): which note plays and the wave level.
    task automatic model(input int sel, input int k, output bit act,
                         output int idx, output bit hi);
        int t = k - 1;
        act = 0; idx = 0; hi = 0;
        for (int n = 0; n < 4; n++) begin
            if (lens[sel][n] == 0) break;
            if (t < lens[sel][n] * UN) begin
                act = 1;
                idx = n;
                hi  = codes[sel][n] != 0 &&
                      ((t / (codes[sel][n] * HP)) % 2 == 1);
                return;
            end
            t -= lens[sel][n] * UN;
        end
    endtask

    typedef struct {
        int    sel;
        int    abort_at;
        int    mlo;
        int    mhi;
        int    restart_at;
        int    exp_busy;
        int    exp_done;
        string tag;
    } vec_t;

    task automatic run(input vec_t v);
        int  stop, nbusy, ndone, ebuzz, estep, ebusy, edone, eled, rest_hi;
        int  rises[4];
        bit  prev, act, hi, m, eb;
        int  idx;
        stop = (v.abort_at > 0 ? v.abort_at : pat_len(v.sel)) + 3;
        nbusy = 0; ndone = 0; ebuzz = 0; estep = 0;
        ebusy = 0; edone = 0; eled = 0; rest_hi = 0; prev = 0;
        rises = '{0, 0, 0, 0};
        @(negedge clk);
        pattern_sel = 2'(v.sel);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= stop; k++) begin
            start = 1'b0;
            abort = 1'b0;
            pattern_sel = 2'(v.sel);
            m = (k >= v.mlo && k <= v.mhi);
            mute = m;
            #1;
            model(v.sel, k, act, idx, hi);
            if (v.abort_at > 0 && k > v.abort_at) act = 0;
            eb = act && hi && !m;
            if (busy !== act) ebusy++;
            if (buzzer_out !== eb) ebuzz++;
            if (LEDR !== {10{eb}}) eled++;
            if (debug_step !== (act ? 2'(idx) : 2'd0)) estep++;
            if (done !== (v.abort_at <= 0 && k == pat_len(v.sel) + 1)) edone++;
            if (busy) nbusy++;
            if (done) ndone++;
            if (act && buzzer_out && !prev) rises[idx]++;
            if (v.sel == 2 && k >= 81 && k <= 120 && buzzer_out) rest_hi++;
            prev = buzzer_out;
            if (k == v.abort_at) abort = 1'b1;
            if (k == v.restart_at) begin
                start = 1'b1;
                pattern_sel = 2'd0;
            end
            @(negedge clk);
        end
        mute = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        check({v.tag, " busy_len"}, nbusy, v.exp_busy);
        check({v.tag, " done_cnt"}, ndone, v.exp_done);
        check({v.tag, " busy_errs"}, ebusy, 0);
        check({v.tag, " buzz_errs"}, ebuzz, 0);
        check({v.tag, " led_errs"}, eled, 0);
        check({v.tag, " step_errs"}, estep, 0);
        check({v.tag, " done_errs"}, edone, 0);
        if (v.sel == 0 && v.mlo == 0 && v.abort_at == 0) begin
            check({v.tag, " rises0"}, rises[0], 10);
            check({v.tag, " rises1"}, rises[1], 20);
        end
        if (v.sel == 2 && v.abort_at == 0)
            check({v.tag, " rest_high"}, rest_hi, 0);
    endtask

    vec_t vecs[6];

    initial begin
        vec_t rv;
        int   tot;
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mute = 1'b0;
        pattern_sel = 2'd0;
        vecs[0] = '{0, 0,  0,  0,  0, 160, 1, "hit"};
        vecs[1] = '{2, 0,  0,  0,  0, 360, 1, "sink"};
        vecs[2] = '{1, 50, 0,  0,  0, 50,  0, "miss_abort"};
        vecs[3] = '{1, 0,  0,  0,  0, 160, 1, "miss_again"};
        vecs[4] = '{3, 0,  0,  0,  30, 280, 1, "win_ignore"};
        vecs[5] = '{0, 0,  20, 40, 0, 160, 1, "hit_mute"};

        #12;
        check("rst busy", int'(busy), 0);
        check("rst buzz", int'(buzzer_out), 0);
        check("rst led", int'(LEDR), 0);
        check("rst step", int'(debug_step), 0);
        check("rst done", int'(done), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run(vecs[i]);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("start_abort busy", int'(busy), 0);
            check("start_abort done", int'(done), 0);
            @(negedge clk);
        end

        for (int r = 0; r < 8; r++) begin
            rv.sel = int'($urandom_range(0, 3));
            tot = pat_len(rv.sel);
            rv.abort_at = ($urandom_range(0, 1) == 1) ?
                          int'($urandom_range(1, tot)) : 0;
            rv.mlo = int'($urandom_range(1, tot));
            rv.mhi = rv.mlo + int'($urandom_range(0, 30));
            rv.restart_at = int'($urandom_range(1, tot));
            rv.exp_busy = rv.abort_at > 0 ? rv.abort_at : tot;
            rv.exp_done = rv.abort_at > 0 ? 0 : 1;
            rv.tag = $sformatf("rand%0d", r);
            run(rv);
        end

        @(negedge clk);
        pattern_sel = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (90) @(negedge clk);
        #1;
        check("pre_rst busy", int'(busy), 1);
        check("pre_rst buzz", int'(buzzer_out), 1);
        check("pre_rst step", int'(debug_step), 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async busy", int'(busy), 0);
        check("async buzz", int'(buzzer_out), 0);
        check("async led", int'(LEDR), 0);
        check("async step", int'(debug_step), 0);
        check("async done", int'(done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst busy", int'(busy), 0);
        check("post_rst done", int'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buzzer_tone_player.md
Name: buzzer_tone_player

Overview:
- Output-side counterpart of the microphone sound detector: drives a digital piezo buzzer with square-wave tone patterns for game events (hit, miss, sink, win).
- The game FSM pulses `start` with a pattern code. The block sequences up to four notes from a fixed pattern ROM, reports `busy`, then pulses `done`.
- It sits between the game control FSM and a GPIO pin. It mirrors tone activity on the LEDs for debugging.

Parameters:
- HP_BASE, 25000: clock cycles per half-period unit. Note code c gives half-period c*HP_BASE cycles (code 1 = 1 kHz at 50 MHz).
- UNIT_CYCLES, 2500000: clock cycles per duration unit (50 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to play a pattern; sampled only in IDLE.
- pattern_sel  in  2  pattern code: 0=HIT, 1=MISS, 2=SINK, 3=WIN; sampled with start.
- abort  in  1  stop playback immediately.
- mute  in  1  forces buzzer_out low; timing is unaffected.
- buzzer_out  out  1  square wave to the piezo pin.
- busy  out  1  high while a pattern is playing.
- done  out  1  one-cycle pulse on normal completion.
- LEDR  out  10  all ones while buzzer_out is high; zeros otherwise.
- debug_step  out  2  index of the current note.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; buzzer_out, busy, done, debug_step and all counters are 0; LEDR=0. Reset mid-playback aborts at once with no done pulse.
- Pattern ROM: each entry is {code[2:0], len[2:0]}. Code 0 is a rest (output held low). len=0 is a terminator. Note duration is len*UNIT_CYCLES cycles.
  - HIT: (2,2),(1,2).
  - MISS: (6,4).
  - SINK: (3,2),(0,1),(3,2),(1,4).
  - WIN: (4,1),(3,1),(2,1),(1,4).
- State IDLE: busy=0. When start=1 and abort=0 on a clock edge:
  - latch pattern_sel;
  - step=0; tone_cnt=0; dur_cnt=0;
  - buzzer_out=0; busy=1 from the next cycle;
  - next state PLAY.
- State PLAY, every cycle:
  - tone_cnt: if tone_cnt==code*HP_BASE-1, clear tone_cnt and toggle buzzer_out (only if code!=0); otherwise increment.
  - dur_cnt: increments each cycle. When dur_cnt==len*UNIT_CYCLES-1 the note ends.
- Note end:
  - clear tone_cnt and dur_cnt; force buzzer_out=0;
  - if step==3 or the next entry has len==0: go to IDLE, busy<=0, done<=1 for exactly one cycle;
  - otherwise step<=step+1.
- Timing:
  - busy stays high for exactly the sum of len*UNIT_CYCLES over the played notes.
  - done rises on the same edge that busy falls.
  - The first toggle occurs code*HP_BASE cycles after busy rises.
- start while busy is ignored; no queueing is performed.
- abort=1 in PLAY: IDLE on the next edge; busy=0, buzzer_out=0, no done pulse. If abort and start are high in the same IDLE cycle, abort wins and nothing starts.
- mute: buzzer_out and LEDR read 0. Internal toggling, busy and done are unchanged, so unmuting mid-note resumes the waveform phase.
- Counter widths:
  - tone_cnt is sized by $clog2(7*HP_BASE).
  - dur_cnt is sized by $clog2(7*UNIT_CYCLES).
  - No overflow is possible for any ROM entry.
- debug_step equals step in PLAY and is 0 in IDLE.

Test Plan (HP_BASE=2, UNIT_CYCLES=40 unless stated):
- HIT:
  - Stimulus: start=1 for one cycle, pattern_sel=0.
  - busy is high for exactly 160 cycles.
  - Cycles 1-80: buzzer period 8, 10 rising edges, debug_step=0.
  - Cycles 81-160: period 4, 20 rising edges, debug_step=1.
  - done is a single pulse on the edge where busy falls.
- SINK:
  - busy is high for 360 cycles.
  - Cycles 81-120 (rest): buzzer_out is constantly 0.
  - The final note has period 4.
  - debug_step steps 0→1→2→3.
- Abort:
  - Start MISS (busy 160 cycles), assert abort at cycle 50.
  - Next cycle: busy=0 and buzzer_out=0.
  - done never pulses.
  - A new start 2 cycles later plays MISS from step 0.
- Busy and simultaneous inputs:
  - Start WIN, then pulse start with pattern_sel=0 at cycle 30: the request is ignored and total busy is 280 cycles.
  - start and abort in the same IDLE cycle: busy stays 0.
- Mute and reset:
  - Play HIT with mute=1 over cycles 20-40: buzzer_out and LEDR are 0 in that window. Toggling resumes at cycle 41 with the same phase as an unmuted run. busy and done timing are unchanged.
  - Drop reset_n asynchronously mid-note: all outputs are 0 immediately, without waiting for a clock edge.
